edge_detect_multi: RTL and testbench

EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

---
 rtl/edge_detect_multi.sv | 121 ++++++++++++
 tb/tb_edge_detect_multi.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronised, glitch-filtered edge detector with per-channel edge select.
// Ports: clk, rst (sync, active-high), level/mode/filt_len in; lvl_filt/tick out.
// Optional EDGE_DETECT_CNT_EN adds cnt_clr in and edge_cnt out (16-bit saturating per channel).
module edge_detect_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH-1:0]     level,
  input  logic [2*CH-1:0]   mode,
  input  logic [FILT_W-1:0] filt_len,
`ifdef EDGE_DETECT_CNT_EN
  input  logic              cnt_clr,
  output logic [16*CH-1:0]  edge_cnt,
`endif
  output logic [CH-1:0]     lvl_filt,
  output logic [CH-1:0]     tick
);

  localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES);

  logic [CH-1:0]     sync_q [SYNC_STAGES];
  logic [CH-1:0]     sync;
  logic [FILT_W-1:0] cnt_q [CH];
  logic [FILT_W-1:0] cnt_d [CH];
  logic [CH-1:0]     filt_q, filt_d;
  logic [CH-1:0]     tick_q, tick_d;
  logic [2:0]        arm_q;
  logic              armed_q;
  logic [FILT_W:0]   len_eff;

  assign sync = sync_q[SYNC_STAGES-1];
  assign len_eff = (filt_len == '0) ? (FILT_W+1)'(1)
                                    : {1'b0, filt_len};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
    end else begin
      sync_q[0] <= level;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
    end
  end

  // Unarmed for SYNC_STAGES+1 edges so the
  // chain flushes before edges can qualify.
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q   <= '0;
      armed_q <= 1'b0;
    end else if (!armed_q) begin
      arm_q <= arm_q + 3'd1;
      if (arm_q == ARM_LAST)
        armed_q <= 1'b1;
    end
  end

  always_comb begin
    filt_d = filt_q;
    tick_d = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!armed_q) begin
        filt_d[i] = sync[i];
        cnt_d[i]  = '0;
      end else if (sync[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (({1'b0, cnt_q[i]} + (FILT_W+1)'(1))
                   >= len_eff) begin
        filt_d[i] = ~filt_q[i];
        cnt_d[i]  = '0;
        // rising uses mode bit 2i, falling 2i+1
        tick_d[i] = filt_q[i] ? mode[2*i+1]
                              : mode[2*i];
      end else begin
        cnt_d[i] = cnt_q[i] + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      tick_q <= '0;
      for (int i = 0; i < CH; i++)
        cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      tick_q <= tick_d;
      for (int i = 0; i < CH; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign lvl_filt = filt_q;
  assign tick     = tick_q;

`ifdef EDGE_DETECT_CNT_EN
  logic [15:0] ecnt_q [CH];

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int i = 0; i < CH; i++)
        ecnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++)
        if (tick_q[i] && ecnt_q[i] != 16'hFFFF)
          ecnt_q[i] <= ecnt_q[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_cnt
    assign edge_cnt[16*g +: 16] = ecnt_q[g];
  end
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// Randomised + directed bench for edge_detect_multi.
// Reference: windowed "last L sync samples all differ" filter model.
module tb_edge_detect_multi;
  localparam int CH = 4;
  localparam int S  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] level;
  logic [7:0] mode;
  logic [7:0] filt_len;
  logic [3:0] lvl_filt;
  logic [3:0] tick;
`ifdef EDGE_DETECT_CNT_EN
  logic        cnt_clr;
  logic [63:0] edge_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  edge_detect_multi #(.CH(CH), .SYNC_STAGES(S), .FILT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .level    (level),
    .mode     (mode),
    .filt_len (filt_len),
`ifdef EDGE_DETECT_CNT_EN
    .cnt_clr  (cnt_clr),
    .edge_cnt (edge_cnt),
`endif
    .lvl_filt (lvl_filt),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [3:0] m_dly [S];
  logic [3:0] m_hist [$];
  logic [3:0] m_filt, m_tick, m_old;
  int         m_arm, m_L;
  bit         m_all;
  int         m_cnt [CH];

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < S; s++) m_dly[s] = '0;
      m_hist.delete();
      m_filt = '0;
      m_tick = '0;
      m_arm  = 0;
      for (int c = 0; c < CH; c++) m_cnt[c] = 0;
    end else begin
      m_old = m_dly[S-1];
      for (int s = S-1; s > 0; s--) m_dly[s] = m_dly[s-1];
      m_dly[0] = level;
      m_L = (filt_len == 0) ? 1 : int'(filt_len);
`ifdef EDGE_DETECT_CNT_EN
      for (int c = 0; c < CH; c++)
        if (cnt_clr) m_cnt[c] = 0;
        else if (m_tick[c] && m_cnt[c] < 65535) m_cnt[c]++;
`endif
      m_tick = '0;
      if (m_arm < S+1) begin
        m_filt = m_old;
        m_arm++;
        m_hist.delete();
      end else begin
        m_hist.push_back(m_old);
        if (m_hist.size() > 300) void'(m_hist.pop_front());
        for (int c = 0; c < CH; c++) begin
          m_all = (m_hist.size() >= m_L);
          if (m_all)
            for (int j = 0; j < m_L; j++)
              if (m_hist[m_hist.size()-1-j][c] == m_filt[c]) m_all = 0;
          if (m_all) begin
            m_tick[c] = m_filt[c] ? mode[2*c+1] : mode[2*c];
            m_filt[c] = ~m_filt[c];
          end
        end
      end
    end
  end

  task automatic do_reset(input logic [3:0] lv, input logic [7:0] md, input logic [7:0] fl);
    rst = 1'b1; level = lv; mode = md; filt_len = fl;
`ifdef EDGE_DETECT_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (S+3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; level = 4'hA; mode = 8'hFF; filt_len = 8'd0;
`ifdef EDGE_DETECT_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (lvl_filt !== 4'h0 || tick !== 4'h0) begin
        n_bad++;
        $display("FAIL reset: lvl_filt=%h tick=%h required 0/0", lvl_filt, tick);
      end
`ifdef EDGE_DETECT_CNT_EN
      n_cmp++;
      if (edge_cnt !== 64'h0) begin
        n_bad++;
        $display("FAIL reset_cnt: edge_cnt=%h required 0", edge_cnt);
      end
`endif
    end
  endtask

  task automatic test_rise_l0;
    logic exp;
    do_reset(4'h0, 8'h55, 8'd0);
    level = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp = (c == 3);
      n_cmp++;
      if (tick[0] !== exp || tick !== m_tick) begin
        n_bad++;
        $display("FAIL rise_l0 c=%0d: tick=%b required bit0=%b model=%b", c, tick, exp, m_tick);
      end
    end
    n_cmp++;
    if (lvl_filt[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL rise_l0_lvl: lvl_filt=%b required bit0=1", lvl_filt);
    end
  endtask

  task automatic test_glitch;
    int nt;
    do_reset(4'h0, 8'hFF, 8'd5);
    nt = 0;
    for (int c = 0; c < 20; c++) begin
      level[1] = (c < 4);
      @(negedge clk);
      nt += int'(tick[1]);
      n_cmp++;
      if (lvl_filt[1] !== 1'b0 || tick !== m_tick) begin
        n_bad++;
        $display("FAIL glitch4 c=%0d: lvl=%b tick=%b required lvl1=0 tick=%b", c, lvl_filt, tick, m_tick);
      end
    end
    n_cmp++;
    if (nt != 0) begin
      n_bad++;
      $display("FAIL glitch4_cnt: ticks=%0d required 0", nt);
    end
    nt = 0;
    for (int c = 0; c < 25; c++) begin
      level[1] = (c < 6);
      @(negedge clk);
      nt += int'(tick[1]);
      n_cmp++;
      if (tick !== m_tick || lvl_filt !== m_filt) begin
        n_bad++;
        $display("FAIL pulse6 c=%0d: tick=%b lvl=%b required %b/%b", c, tick, lvl_filt, m_tick, m_filt);
      end
    end
    n_cmp++;
    if (nt != 2) begin
      n_bad++;
      $display("FAIL pulse6_cnt: ticks=%0d required 2", nt);
    end
  endtask

  task automatic test_held_high;
    rst = 1'b1; level = 4'hF; mode = 8'hFF; filt_len = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      n_cmp++;
      if (tick !== 4'h0) begin
        n_bad++;
        $display("FAIL held_high c=%0d: tick=%b required 0000", c, tick);
      end
    end
    n_cmp++;
    if (lvl_filt !== 4'hF) begin
      n_bad++;
      $display("FAIL held_high_lvl: lvl_filt=%h required f", lvl_filt);
    end
  endtask

  task automatic test_simultaneous;
    logic [3:0] exp;
    do_reset(4'h0, 8'b10_01_11_00, 8'd0);
    level = 4'hF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp = (c == 3) ? 4'b0110 : 4'b0000;
      n_cmp++;
      if (tick !== exp) begin
        n_bad++;
        $display("FAIL simul_rise c=%0d: tick=%b required %b", c, tick, exp);
      end
    end
    level = 4'h0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp = (c == 3) ? 4'b1010 : 4'b0000;
      n_cmp++;
      if (tick !== exp) begin
        n_bad++;
        $display("FAIL simul_fall c=%0d: tick=%b required %b", c, tick, exp);
      end
    end
  endtask

  task automatic test_rst_mid;
    do_reset(4'h0, 8'h55, 8'd0);
    level = 4'b0001;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tick !== 4'b0001) begin
      n_bad++;
      $display("FAIL rst_mid_pre: tick=%b required 0001", tick);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tick !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_mid_clr: tick=%b required 0000", tick);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (tick !== 4'b0000) begin
        n_bad++;
        $display("FAIL rst_mid_post c=%0d: tick=%b required 0000", c, tick);
      end
    end
  endtask

  task automatic test_random;
    do_reset(4'h0, 8'hFF, 8'd2);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      n_cmp++;
      if (tick !== m_tick || lvl_filt !== m_filt) begin
        n_bad++;
        $display("FAIL random c=%0d: tick=%b lvl=%b required %b/%b", c, tick, lvl_filt, m_tick, m_filt);
      end
`ifdef EDGE_DETECT_CNT_EN
      for (int k = 0; k < CH; k++) begin
        n_cmp++;
        if (int'(edge_cnt[16*k +: 16]) != m_cnt[k]) begin
          n_bad++;
          $display("FAIL random_cnt c=%0d ch=%0d: %0d required %0d", c, k, edge_cnt[16*k +: 16], m_cnt[k]);
        end
      end
      cnt_clr = ($urandom_range(0, 29) == 0);
`endif
      level = level ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 9) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 24) == 0) filt_len = 8'($urandom_range(0, 6));
    end
  endtask

`ifdef EDGE_DETECT_CNT_EN
  task automatic test_cnt_sat;
    do_reset(4'h0, 8'b00_11_00_00, 8'd0);
    for (int c = 0; c < 70000; c++) begin
      level[2] = ~level[2];
      @(negedge clk);
    end
    n_cmp++;
    if (edge_cnt[47:32] !== 16'hFFFF || m_cnt[2] != 65535) begin
      n_bad++;
      $display("FAIL cnt_sat: edge_cnt[47:32]=%h required ffff (model %0d)", edge_cnt[47:32], m_cnt[2]);
    end
    n_cmp++;
    if (tick[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL cnt_sat_tick: tick=%b required bit2=1", tick);
    end
    cnt_clr = 1'b1;
    level[2] = ~level[2];
    @(negedge clk);
    cnt_clr = 1'b0;
    n_cmp++;
    if (edge_cnt[47:32] !== 16'h0) begin
      n_bad++;
      $display("FAIL cnt_clr: edge_cnt[47:32]=%h required 0", edge_cnt[47:32]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rise_l0();
    test_glitch();
    test_held_high();
    test_simultaneous();
    test_rst_mid();
    test_random();
`ifdef EDGE_DETECT_CNT_EN
    test_cnt_sat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
